eth_rx_port_demux: RTL and testbench
====================================

ETH_RX_PORT_DEMUX -- requirements
Module: eth_rx_port_demux

Interface
REQ-001 Parameter NUM_CH, default 4, legal 1..8: number of UDP payload output channels.
REQ-002 Parameter CNT_W, default 32, legal 8..48: width of each statistics counter.
REQ-003 rx_axis_aclk  in  1  single clock; all logic rising-edge.
REQ-004 rx_axis_areset  in  1  reset, synchronous, active-high.
REQ-005 s_axis_tdata/tkeep/tvalid/tlast/tuser  in  64/8/1/1/1  UDP stream; first beat of each frame is the 8-byte UDP header, byte 0 in tdata[7:0]; no tready.
REQ-006 cfg_port  in  NUM_CH*16  destination port for channel i in bits [16i+15:16i].
REQ-007 cfg_en  in  NUM_CH  channel i enabled when bit i is 1.
REQ-008 cnt_clr  in  1  synchronous clear of all counters.
REQ-009 m_axis_tdata/tkeep/tlast/tuser  out  64/8/1/1  payload bus shared by all channels.
REQ-010 m_axis_tvalid  out  NUM_CH  per-channel valid, one-hot or zero.
REQ-011 m_src_port, m_dst_port  out  16 each  ports of the frame currently being forwarded.
REQ-012 frm_cnt  out  NUM_CH*CNT_W  forwarded-frame count per channel; drop_cnt  out  CNT_W  dropped-frame count.

Function
REQ-013 FSM states: HDR (expect header beat), FWD, DROP; HDR is the reset state.
REQ-014 In HDR on a valid beat, dst port = {tdata[23:16], tdata[31:24]}, src port = {tdata[7:0], tdata[15:8]}.
REQ-015 Channel i matches when cfg_en[i]=1 and cfg_port slice i equals dst port; cfg sampled only on the header beat.
REQ-016 Several matches: lowest index wins.
REQ-017 Header beat with tlast=0: match -> FWD with selected channel latched; no match -> DROP.
REQ-018 Header beat with tlast=1 (no payload): frame dropped, drop_cnt increments, FSM stays HDR.
REQ-019 Header beat never appears on the output; m_src_port/m_dst_port load on the header beat of matched frames and hold until the next matched header.
REQ-020 In FWD each input beat appears on the output exactly 1 cycle later, data/keep/last/user registered unchanged, only the latched channel's tvalid bit set.
REQ-021 FWD beat with tlast=1: FSM -> HDR; frm_cnt of that channel increments in the same cycle the output tlast is registered, regardless of tuser.
REQ-022 In DROP beats are discarded, all m_axis_tvalid bits 0; on tlast FSM -> HDR and drop_cnt increments.
REQ-023 s_axis_tvalid=0 cycles: FSM holds, all m_axis_tvalid 0, m_axis_tdata/tkeep/tlast/tuser hold last value.
REQ-024 Next frame's header may arrive in the cycle after the previous tlast; no idle cycle required, no beat lost.
REQ-025 Counters saturate at 2^CNT_W-1 and do not wrap.
REQ-026 cnt_clr zeroes all counters next edge; cnt_clr coincident with an increment: clear wins, increment lost.
REQ-027 cfg_en/cfg_port changes mid-frame do not affect the frame in progress.

Reset
REQ-028 While rx_axis_areset=1: FSM -> HDR, m_axis_tvalid=0, m_axis_tdata=0, tkeep=0, tlast=0, tuser=0, m_src_port=0, m_dst_port=0, all counters 0.
REQ-029 Reset asserted mid-frame aborts it with no tlast emitted; first valid beat after reset release is parsed as a header.
REQ-030 Reset takes priority over cnt_clr and all stream activity.

Verification
REQ-031 cfg_port ch1=0x1F90, cfg_en=0b0010; frame header dst bytes 0x1F,0x90 + 3 payload beats -> 3 beats on tvalid=0b0010, each 1 cycle after input, last with tlast=1; frm_cnt[1]=1, m_dst_port=0x1F90.
REQ-032 Header dst 0x0050 matches nothing -> no output valid; drop_cnt=1 after tlast.
REQ-033 ch0 and ch2 both 0x1234 enabled -> frame on ch0 only; ch0 disabled then -> next frame on ch2.
REQ-034 Back-to-back frames, header on cycle after tlast, tuser=1 on last beat of first -> both forwarded intact, tuser passed, counts 2.
REQ-035 CNT_W=8, 256 matched frames on ch0 -> frm_cnt[0]=255; cnt_clr coincident with a tlast -> 0.
REQ-036 Reset for 1 cycle during payload beat 2 of 4 -> no further valid, no tlast; next frame parsed correctly, counters 0 before it.

Source files
------------

// File: rtl/eth_rx_port_demux.sv
// UDP receive demultiplexer: parses the 8-byte UDP header beat, steers the payload
// to the channel whose configured destination port matches, and keeps per-channel statistics.
module eth_rx_port_demux #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic                    rx_axis_aclk,
  input  logic                    rx_axis_areset,
  input  logic [63:0]             s_axis_tdata,
  input  logic [7:0]              s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tuser,
  input  logic [NUM_CH*16-1:0]    cfg_port,
  input  logic [NUM_CH-1:0]       cfg_en,
  input  logic                    cnt_clr,
  output logic [63:0]             m_axis_tdata,
  output logic [7:0]              m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  output logic [NUM_CH-1:0]       m_axis_tvalid,
  output logic [15:0]             m_src_port,
  output logic [15:0]             m_dst_port,
  output logic [NUM_CH*CNT_W-1:0] frm_cnt,
  output logic [CNT_W-1:0]        drop_cnt
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CH_W-1:0]   r_ch;
  logic [63:0]       r_tdata;
  logic [7:0]        r_tkeep;
  logic              r_tlast;
  logic              r_tuser;
  logic [NUM_CH-1:0] r_tvalid;
  logic [15:0]       r_src_port;
  logic [15:0]       r_dst_port;
  logic [CNT_W-1:0]  r_drop_cnt;

  logic [15:0]       w_hdr_dst;
  logic [15:0]       w_hdr_src;
  logic [NUM_CH-1:0] w_match;
  logic              w_any_match;
  logic [CH_W-1:0]   w_sel_ch;
  logic [NUM_CH-1:0] w_ch_onehot;
  logic              w_hdr_load;
  logic              w_fwd_beat;
  logic              w_frm_inc;
  logic              w_drop_inc;

  // Ports travel in network byte order: the first byte on the wire is the MSB.
  assign w_hdr_src = {s_axis_tdata[7:0],   s_axis_tdata[15:8]};
  assign w_hdr_dst = {s_axis_tdata[23:16], s_axis_tdata[31:24]};

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_match
      assign w_match[gi]     = cfg_en[gi] && (cfg_port[16*gi +: 16] == w_hdr_dst);
      assign w_ch_onehot[gi] = (r_ch == CH_W'(gi));
    end
  endgenerate

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    w_any_match = 1'b0;
    w_sel_ch    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_any_match = 1'b1;
        w_sel_ch    = CH_W'(i);
      end
    end
  end

  always_ff @(posedge rx_axis_aclk) begin
    if (rx_axis_areset) begin
      r_state <= HDR;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_hdr_load   = 1'b0;
    w_fwd_beat   = 1'b0;
    w_frm_inc    = 1'b0;
    w_drop_inc   = 1'b0;
    case (r_state)
      HDR: begin
        if (s_axis_tvalid) begin
          if (s_axis_tlast) begin
            w_drop_inc = 1'b1;
          end else if (w_any_match) begin
            w_hdr_load   = 1'b1;
            w_state_next = FWD;
          end else begin
            w_state_next = DROP;
          end
        end
      end
      FWD: begin
        if (s_axis_tvalid) begin
          w_fwd_beat = 1'b1;
          if (s_axis_tlast) begin
            w_frm_inc    = 1'b1;
            w_state_next = HDR;
          end
        end
      end
      DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          w_drop_inc   = 1'b1;
          w_state_next = HDR;
        end
      end
      default: w_state_next = HDR;
    endcase
  end

  // Output payload registers hold their last value whenever nothing is forwarded.
  always_ff @(posedge rx_axis_aclk) begin
    if (rx_axis_areset) begin
      r_ch       <= '0;
      r_tdata    <= '0;
      r_tkeep    <= '0;
      r_tlast    <= 1'b0;
      r_tuser    <= 1'b0;
      r_tvalid   <= '0;
      r_src_port <= '0;
      r_dst_port <= '0;
    end else begin
      r_tvalid <= '0;
      if (w_hdr_load) begin
        r_ch       <= w_sel_ch;
        r_src_port <= w_hdr_src;
        r_dst_port <= w_hdr_dst;
      end
      if (w_fwd_beat) begin
        r_tvalid <= w_ch_onehot;
        r_tdata  <= s_axis_tdata;
        r_tkeep  <= s_axis_tkeep;
        r_tlast  <= s_axis_tlast;
        r_tuser  <= s_axis_tuser;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cnt
      logic [CNT_W-1:0] r_frm_cnt;

      always_ff @(posedge rx_axis_aclk) begin
        if (rx_axis_areset || cnt_clr) begin
          r_frm_cnt <= '0;
        end else if (w_frm_inc && w_ch_onehot[gi] && (r_frm_cnt != {CNT_W{1'b1}})) begin
          r_frm_cnt <= r_frm_cnt + CNT_W'(1);
        end
      end

      assign frm_cnt[gi*CNT_W +: CNT_W] = r_frm_cnt;
    end
  endgenerate

  always_ff @(posedge rx_axis_aclk) begin
    if (rx_axis_areset || cnt_clr) begin
      r_drop_cnt <= '0;
    end else if (w_drop_inc && (r_drop_cnt != {CNT_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tkeep  = r_tkeep;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tvalid = r_tvalid;
  assign m_src_port    = r_src_port;
  assign m_dst_port    = r_dst_port;
  assign drop_cnt      = r_drop_cnt;

endmodule

// File: tb/tb_eth_rx_port_demux.sv
// Scoreboard bench for eth_rx_port_demux: frames are modelled as they are driven and
// every forwarded beat, counter and port register is compared against the model.
module tb_eth_rx_port_demux;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    rst_q = 1'b0;
  logic [63:0]             s_tdata = '0;
  logic [7:0]              s_tkeep = '0;
  logic                    s_tvalid = 1'b0;
  logic                    s_tlast = 1'b0;
  logic                    s_tuser = 1'b0;
  logic [NUM_CH*16-1:0]    cfg_port = '0;
  logic [NUM_CH-1:0]       cfg_en = '0;
  logic                    cnt_clr = 1'b0;
  logic [63:0]             m_tdata;
  logic [7:0]              m_tkeep;
  logic                    m_tlast;
  logic                    m_tuser;
  logic [NUM_CH-1:0]       m_tvalid;
  logic [15:0]             m_src;
  logic [15:0]             m_dst;
  logic [NUM_CH*CNT_W-1:0] frm_cnt;
  logic [CNT_W-1:0]        drop_cnt;

  eth_rx_port_demux #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .rx_axis_aclk  (clk),
    .rx_axis_areset(rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .cfg_port      (cfg_port),
    .cfg_en        (cfg_en),
    .cnt_clr       (cnt_clr),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_src_port    (m_src),
    .m_dst_port    (m_dst),
    .frm_cnt       (frm_cnt),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
    int          at;
  } beat_t;

  beat_t       sb[$];
  int          n_chk = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          exp_frm[NUM_CH];
  int          exp_drop = 0;
  logic [15:0] exp_src = '0;
  logic [15:0] exp_dst = '0;
  logic [63:0] last_d = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_q <= rst;
  end

  always @(negedge clk) begin
    if (rst_q) begin
      chk("rst_valid", 64'(m_tvalid), 64'd0);
      chk("rst_data", m_tdata, 64'd0);
      chk("rst_klu", {54'd0, m_tkeep, m_tlast, m_tuser}, 64'd0);
      chk("rst_ports", {32'd0, m_src, m_dst}, 64'd0);
      last_d = '0;
    end else if (m_tvalid != '0) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 64'(m_tvalid), 64'd0);
      end else begin
        beat_t b;
        logic [NUM_CH-1:0] oh;
        b  = sb.pop_front();
        oh = '0;
        oh[b.ch] = 1'b1;
        chk("out_valid", 64'(m_tvalid), 64'(oh));
        chk("out_data", m_tdata, b.d);
        chk("out_klu", {54'd0, m_tkeep, m_tlast, m_tuser}, {54'd0, b.k, b.l, b.u});
        chk("out_latency", 64'(cyc), 64'(b.at));
        $display("beat ch=%0d data=%h keep=%h last=%0b user=%0b cyc=%0d",
                 b.ch, m_tdata, m_tkeep, m_tlast, m_tuser, cyc);
      end
      last_d = m_tdata;
    end else begin
      chk("idle_hold", m_tdata, last_d);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_inc(input int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NUM_CH; i++) exp_frm[i] = 0;
    exp_drop = 0;
  endtask

  task automatic check_state(input string tag);
    s_tvalid = 1'b0;
    tick();
    for (int i = 0; i < NUM_CH; i++)
      chk($sformatf("%s_frm%0d", tag, i), 64'(frm_cnt[i*CNT_W +: CNT_W]), 64'(exp_frm[i]));
    chk({tag, "_drop"}, 64'(drop_cnt), 64'(exp_drop));
    chk({tag, "_src"}, 64'(m_src), 64'(exp_src));
    chk({tag, "_dst"}, 64'(m_dst), 64'(exp_dst));
    $display("check %s frm0=%0d frm1=%0d frm2=%0d frm3=%0d drop=%0d", tag,
             exp_frm[0], exp_frm[1], exp_frm[2], exp_frm[3], exp_drop);
  endtask

  // rst_at > 0 asserts reset for one cycle while that payload beat is driven.
  task automatic send_frame(input logic [15:0] src, input logic [15:0] dst, input int npay,
                            input bit user_last, input bit mid_toggle, input bit clr_on_last,
                            input int rst_at, input bit gaps);
    int          ch;
    logic [63:0] d;
    ch = -1;
    for (int i = 0; i < NUM_CH; i++)
      if (ch < 0 && cfg_en[i] && cfg_port[16*i +: 16] == dst) ch = i;
    d = {$urandom, $urandom};
    d[7:0]   = src[15:8];
    d[15:8]  = src[7:0];
    d[23:16] = dst[15:8];
    d[31:24] = dst[7:0];
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = 8'hFF;
    s_tlast  = (npay == 0);
    s_tuser  = 1'b0;
    tick();
    if (npay == 0) begin
      exp_drop = sat_inc(exp_drop);
      return;
    end
    if (ch >= 0) begin
      exp_src = src;
      exp_dst = dst;
    end
    for (int b = 1; b <= npay; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_tvalid = 1'b0;
        tick();
      end
      s_tvalid = 1'b1;
      s_tdata  = {$urandom, $urandom};
      s_tlast  = (b == npay);
      s_tkeep  = s_tlast ? 8'($urandom_range(1, 255)) : 8'hFF;
      s_tuser  = s_tlast && user_last;
      if (b == rst_at) rst = 1'b1;
      if (clr_on_last && s_tlast) cnt_clr = 1'b1;
      if (ch >= 0 && b != rst_at)
        sb.push_back('{ch: ch, d: s_tdata, k: s_tkeep, l: s_tlast, u: s_tuser, at: cyc + 1});
      tick();
      cnt_clr = 1'b0;
      if (b == rst_at) begin
        rst      = 1'b0;
        s_tvalid = 1'b0;
        clear_model();
        exp_src = '0;
        exp_dst = '0;
        return;
      end
      if (mid_toggle && b == 1) begin
        cfg_en   = ~cfg_en;
        cfg_port = ~cfg_port;
      end
    end
    if (clr_on_last) clear_model();
    else if (ch >= 0) exp_frm[ch] = sat_inc(exp_frm[ch]);
    else exp_drop = sat_inc(exp_drop);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pool [4];
    clear_model();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_state("reset");

    // Single matched channel
    cfg_port = {16'h0004, 16'h0003, 16'h1F90, 16'h0001};
    cfg_en   = 4'b0010;
    send_frame(16'hC000, 16'h1F90, 3, 0, 0, 0, 0, 0);
    check_state("ch1_basic");

    // No match, then header-only frame on a matching port
    send_frame(16'hC001, 16'h0050, 2, 0, 0, 0, 0, 1);
    check_state("nomatch");
    send_frame(16'hC002, 16'h1F90, 0, 0, 0, 0, 0, 0);
    check_state("hdr_only");

    // Priority: lowest index wins, then disable it
    cfg_port = {16'h0004, 16'h1234, 16'h1F90, 16'h1234};
    cfg_en   = 4'b0101;
    send_frame(16'h0A0B, 16'h1234, 2, 0, 0, 0, 0, 1);
    check_state("prio_ch0");
    cfg_en = 4'b0100;
    send_frame(16'h0A0C, 16'h1234, 2, 0, 0, 0, 0, 1);
    check_state("prio_ch2");

    // Back-to-back frames, tuser on first last beat
    cfg_en = 4'b0010;
    send_frame(16'h1111, 16'h1F90, 2, 1, 0, 0, 0, 0);
    send_frame(16'h2222, 16'h1F90, 3, 0, 0, 0, 0, 0);
    check_state("b2b");

    // Config changes mid-frame do not affect the frame in flight
    cfg_port = {16'h0004, 16'h1234, 16'h1F90, 16'h1234};
    cfg_en   = 4'b0010;
    send_frame(16'h3333, 16'h1F90, 3, 0, 1, 0, 0, 0);
    cfg_port = {16'h0004, 16'h1234, 16'h1F90, 16'h1234};
    cfg_en   = 4'b0000;
    send_frame(16'h3334, 16'h1F90, 3, 0, 1, 0, 0, 0);
    check_state("midcfg");

    // Reset during payload beat 2 of 4
    cfg_port = {16'h0004, 16'h1234, 16'h1F90, 16'h1234};
    cfg_en   = 4'b0010;
    send_frame(16'h4444, 16'h1F90, 4, 0, 0, 0, 2, 0);
    check_state("midrst");
    send_frame(16'h5555, 16'h1F90, 2, 0, 0, 0, 0, 0);
    check_state("post_rst");

    // Saturation and clear-over-increment
    cfg_port = {16'h0004, 16'h0003, 16'h0002, 16'hABCD};
    cfg_en   = 4'b0001;
    for (int n = 0; n < 256; n++) send_frame(16'h6666, 16'hABCD, 1, 0, 0, 0, 0, 0);
    check_state("saturate");
    send_frame(16'h7777, 16'hABCD, 2, 0, 0, 1, 0, 0);
    check_state("clr_on_last");

    // Random traffic over a small port pool
    pool[0] = 16'h0100; pool[1] = 16'h0200; pool[2] = 16'h0300; pool[3] = 16'h0999;
    cfg_port = {16'h0300, 16'h0200, 16'h0100, 16'h0100};
    for (int n = 0; n < 30; n++) begin
      cfg_en = 4'($urandom_range(0, 15));
      send_frame(16'($urandom), pool[$urandom_range(0, 3)], $urandom_range(0, 4),
                 1'($urandom_range(0, 1)), 0, 0, 0, 1);
    end
    check_state("random");

    repeat (3) tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
